// File: rtl/img_feeder.sv
// img_feeder: streams one image into the accelerator's image memory, starts it,
// and hands back the captured prediction over a valid/ready result port.
module img_feeder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 900,
  parameter int ADDR_W = 10,
  parameter int PRED_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              img_wen,
  output logic [ADDR_W-1:0] img_waddr,
  output logic [DATA_W-1:0] img_wdata,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic [PRED_W-1:0] acc_predict,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [PRED_W-1:0] r_predict,
  output logic              busy,
  output logic [CNT_W-1:0]  img_count
);
  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_RESULT} state_t;
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_wptr;
  logic                r_done_q;
  logic [PRED_W-1:0]   r_pred;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_acc, w_last, w_done_rise, w_res_take;
  assign w_acc       = s_valid & (r_state == S_LOAD);
  assign w_last      = r_wptr == ADDR_W'(DEPTH - 1);
  // only a fresh rising edge of done counts, so a level left from the last image is ignored
  assign w_done_rise = acc_done & ~r_done_q;
  assign w_res_take  = (r_state == S_RESULT) & r_ready;
  assign s_ready   = r_state == S_LOAD;
  assign img_wen   = w_acc;
  assign img_waddr = r_wptr;
  assign img_wdata = s_data;
  assign acc_start = r_state == S_START;
  assign r_valid   = r_state == S_RESULT;
  assign busy      = r_state != S_LOAD;
  assign r_predict = r_pred;
  assign img_count = r_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:   w_next = (w_acc && w_last) ? S_START : S_LOAD;
      S_START:  w_next = S_WAIT;
      S_WAIT:   w_next = w_done_rise ? S_RESULT : S_WAIT;
      S_RESULT: w_next = r_ready ? S_LOAD : S_RESULT;
      default:  w_next = S_LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_LOAD;
      r_wptr   <= '0;
      r_done_q <= 1'b0;
      r_pred   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_done_q <= acc_done;
      r_wptr   <= w_acc ? (w_last ? '0 : r_wptr + ADDR_W'(1)) : r_wptr;
      r_pred   <= (r_state == S_WAIT && w_done_rise) ? acc_predict : r_pred;
      r_cnt    <= w_res_take ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end
endmodule

// File: tb/tb_img_feeder.sv
// tb_img_feeder: scoreboard bench; stimulus queues expected writes and predictions,
// a negedge monitor pops and compares whenever the DUT writes or hands off a result.
module tb_img_feeder;
  localparam int DEPTH = 900, ADDR_W = 10, DATA_W = 32, PRED_W = 4, CNT_W = 16;
  logic clk = 0, rst = 1, s_valid = 0, acc_done = 0, r_ready = 0;
  logic [DATA_W-1:0] s_data = '0;
  logic [PRED_W-1:0] acc_predict = '0;
  logic s_ready, img_wen, acc_start, r_valid, busy;
  logic [ADDR_W-1:0] img_waddr;
  logic [DATA_W-1:0] img_wdata;
  logic [PRED_W-1:0] r_predict;
  logic [CNT_W-1:0]  img_count;
  logic [ADDR_W+DATA_W-1:0] wq[$];
  logic [PRED_W-1:0] rq[$];
  logic [ADDR_W+DATA_W-1:0] w_exp;
  logic [PRED_W-1:0] p_exp;
  int n_chk = 0, n_fail = 0, cyc = 0, last_cyc = -10, n_start = 0, exp_cnt = 0;
  img_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRED_W(PRED_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .img_wen(img_wen), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .acc_start(acc_start), .acc_done(acc_done), .acc_predict(acc_predict),
    .r_valid(r_valid), .r_ready(r_ready), .r_predict(r_predict),
    .busy(busy), .img_count(img_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (img_wen) begin
      chk("write_while_valid", s_valid, 1);
      if (wq.size() == 0) chk("write_unexpected", {img_waddr, img_wdata}, 0);
      else begin
        w_exp = wq.pop_front();
        chk("write_addr_data", {img_waddr, img_wdata}, w_exp);
      end
    end
    if (acc_start) begin
      n_start++;
      chk("start_timing", cyc, last_cyc + 1);
    end
    if (img_wen && img_waddr == ADDR_W'(DEPTH - 1)) last_cyc = cyc;
    if (r_valid && r_ready) begin
      if (rq.size() == 0) chk("result_unexpected", r_predict, 0);
      else begin
        p_exp = rq.pop_front();
        chk("result_predict", r_predict, p_exp);
      end
    end
  end
  task automatic load_img(input logic [31:0] base, input bit bub, input int n);
    for (int i = 0; i < n; i++) begin
      if (bub) repeat ($urandom_range(0, 2)) begin
        s_valid = 0; s_data = $urandom; @(posedge clk); #1;
      end
      s_valid = 1; s_data = base + 32'(i);
      wq.push_back({ADDR_W'(i), base + 32'(i)});
      @(posedge clk); #1;
    end
    s_valid = 0;
    if (n == DEPTH) begin
      chk("start_pulse", acc_start, 1);
      chk("busy_start", busy, 1);
      chk("sready_start", s_ready, 0);
      @(posedge clk); #1;
      chk("start_one_cycle", acc_start, 0);
    end
  endtask
  task automatic finish_acc(input logic [PRED_W-1:0] p, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    chk("no_valid_in_wait", r_valid, 0);
    acc_done = 1; acc_predict = p; rq.push_back(p);
    @(posedge clk); #1;
    acc_predict = ~p;
    chk("rvalid_after_done", r_valid, 1);
    chk("rpredict_captured", r_predict, p);
  endtask
  task automatic take(input logic [PRED_W-1:0] p, input int hold);
    s_valid = hold > 0; s_data = 32'hdead_beef;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("bp_rvalid", r_valid, 1);
      chk("bp_rpredict", r_predict, p);
      chk("bp_sready", s_ready, 0);
      chk("bp_wen", img_wen, 0);
    end
    s_valid = 0; r_ready = 1;
    @(posedge clk); #1;
    r_ready = 0; exp_cnt++;
    chk("load_resumes", s_ready, 1);
    chk("busy_clear", busy, 0);
    chk("rvalid_clear", r_valid, 0);
    chk("img_count", img_count, exp_cnt);
  endtask
  task automatic chk_reset();
    chk("rst_sready", s_ready, 1);
    chk("rst_wen", img_wen, 0);
    chk("rst_waddr", img_waddr, 0);
    chk("rst_wdata_pass", img_wdata, s_data);
    chk("rst_start", acc_start, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_rpredict", r_predict, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", img_count, 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    s_data = 32'h1234_5678;
    #1 chk_reset();
    @(posedge clk); @(negedge clk) rst = 0;
    @(posedge clk); #1;
    // image 1: contiguous ramp 0..0x383, predict 7
    load_img(32'h0, 0, DEPTH);
    finish_acc(4'd7, 3);
    take(4'd7, 0);
    acc_done = 0;
    // image 2: bubbles; done left high afterwards to act as stale
    load_img(32'h0001_0000, 1, DEPTH);
    finish_acc(4'd2, 2);
    take(4'd2, 0);
    // image 3: stale done through START and 5 WAIT cycles, low 3, then rise
    load_img(32'h0002_0000, 0, DEPTH);
    repeat (5) begin chk("stale_ignored", r_valid, 0); @(posedge clk); #1; end
    acc_done = 0;
    repeat (3) begin @(posedge clk); #1; chk("done_low_wait", r_valid, 0); end
    finish_acc(4'd3, 0);
    take(4'd3, 20);
    acc_done = 0;
    // image 4: reset mid-load after 450 words
    load_img(32'h0003_0000, 0, 450);
    s_data = 32'hcafe_0001;
    #2 rst = 1;
    #1 chk_reset();
    wq.delete(); exp_cnt = 0;
    @(posedge clk); @(negedge clk) rst = 0;
    @(posedge clk); #1;
    n_start = 0;
    // three back-to-back images, predicts 1, 5, 9
    load_img(32'h0004_0000, 0, DEPTH); finish_acc(4'd1, 4); take(4'd1, 0); acc_done = 0;
    load_img(32'h0005_0000, 0, DEPTH); finish_acc(4'd5, 1); take(4'd5, 2); acc_done = 0;
    load_img(32'h0006_0000, 0, DEPTH); finish_acc(4'd9, 6); take(4'd9, 0); acc_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_pulses", n_start, 3);
    chk("final_count", img_count, 3);
    chk("writes_drained", wq.size(), 0);
    chk("results_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/img_feeder.md
# img_feeder

Upstream front-end for the CNN accelerator `Top`. Accepts one image as a valid/ready stream of 32-bit words and writes it into the image memory that `Top` reads through `bram_img_addr`/`bram_img_data`. After the last word it pulses `start` to `Top` and waits for `done`. It then captures `predict` and returns it on a valid/ready result port. This replaces bench-side memory preloading, so images stream back-to-back.

## Interface
- DATA_W, 32, image word width (matches `img_wid`)
- DEPTH, 900, words per image
- ADDR_W, 10, image memory address width
- PRED_W, 4, prediction width (matches `PS_wid`)
- CNT_W, 16, processed-image counter width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  block accepts a word
- s_data  in  DATA_W  input image word
- img_wen  out  1  image memory write enable
- img_waddr  out  ADDR_W  image memory write address
- img_wdata  out  DATA_W  image memory write data
- acc_start  out  1  start pulse to `Top`
- acc_done  in  1  `Top` done (level)
- acc_predict  in  PRED_W  `Top` predict
- r_valid  out  1  result valid
- r_ready  in  1  result consumer ready
- r_predict  out  PRED_W  captured prediction
- busy  out  1  high outside LOAD state
- img_count  out  CNT_W  images completed (result handshakes)

## Operation
- FSM states: LOAD, START, WAIT, RESULT. Reset state is LOAD.
- LOAD:
  - s_ready=1.
  - Accept condition is s_valid&s_ready.
  - On accept: img_wen=1, img_waddr=wptr, img_wdata=s_data (combinational, same cycle). Then wptr increments.
  - Accepting the word at wptr=DEPTH-1 sets wptr to 0 and moves to START.
- START: acc_start=1 for exactly this one cycle. Next state is WAIT.
- WAIT:
  - done_q is a register of acc_done.
  - Completion is acc_done & ~done_q, i.e. a rising edge. A `done` level left over from the previous image is therefore ignored.
  - On completion: r_predict <= acc_predict, then go to RESULT.
- RESULT:
  - r_valid=1 and r_predict held stable until r_ready.
  - On r_valid&r_ready: img_count increments (wraps modulo 2^CNT_W), then go to LOAD.
- s_ready=0 and img_wen=0 in START/WAIT/RESULT. Image memory is never written while `Top` reads it.
- Write addresses span 0..DEPTH-1 only, and are never ≥DEPTH.
- acc_done and acc_predict are ignored outside WAIT.

## Timing
- Reset values: s_ready=1 (state LOAD), img_wen=0, img_waddr=0, img_wdata=s_data passthrough, acc_start=0, r_valid=0, r_predict=0, busy=0, img_count=0, wptr=0, done_q=0.
- Reset mid-operation: immediate return to LOAD with wptr=0. A partially loaded image is discarded. Any pending result is dropped and img_count is cleared.
- Input throughput is one word per cycle. DEPTH words need at least DEPTH cycles.
- The last word is accepted in cycle N. acc_start=1 in cycle N+1. WAIT begins in cycle N+2.
- acc_done first sampled high (with done_q=0) in cycle M. r_valid=1 from cycle M+1.
- Result accepted in cycle R. s_ready=1 in cycle R+1.
- Stalls:
  - s_valid=0 in LOAD inserts idle cycles; wptr holds.
  - r_ready=0 holds RESULT indefinitely; r_predict is unchanged.
- acc_done high on entry to WAIT with done_q=1: no completion is taken until acc_done falls and rises again.
- acc_start, busy, r_valid, s_ready and img_wen are all decoded from state (Moore), except that img_wen also requires s_valid.

## Test plan
- Single image: 900 words 0x00000000..0x00000383 sent back-to-back. Required response:
  - img_waddr 0..899 with matching img_wdata.
  - acc_start one cycle high, exactly 1 cycle after word 899.
  - Model raises acc_done with acc_predict=7 → r_valid=1 next cycle, r_predict=7.
  - r_ready=1 → img_count=1, s_ready=1.
- Input bubbles: s_valid toggles randomly at 50% duty. Required: exactly 900 writes, addresses contiguous, no write while s_valid=0.
- Stale done: hold acc_done=1 from the previous image through START and the first 5 WAIT cycles, drop it 3 cycles, then raise it with predict=3. Required: r_valid only after the new rising edge; r_predict=3.
- Result backpressure: r_ready=0 for 20 cycles. Required: r_valid stays 1, r_predict is stable, s_ready=0 and img_wen=0 throughout; LOAD resumes the cycle after r_ready=1.
- Reset mid-load: assert rst after 450 words, mid-cycle (asynchronous). Required: outputs immediately at reset values. A fresh 900-word image then loads from addr 0, and acc_start occurs only after 900 new words.
- Back-to-back: 3 images with predicts 1, 5, 9. Required: three acc_start pulses, r_predict sequence 1, 5, 9, img_count=3.
